// File: rtl/enc_pkg.sv
// Shared types and helpers for the 4-to-2 handshake encoder.
package enc_pkg;

  localparam int NLINES = 4;
  localparam int CODEW  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Turns a served code back into the pending bit it retires.
  function automatic logic [NLINES-1:0] onehot2(input logic [CODEW-1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder; HIGH_FIRST picks which end wins.
module prio_enc4
  import enc_pkg::*;
#(
  parameter int HIGH_FIRST = 1
) (
  input  logic [NLINES-1:0] i_req,
  output logic [CODEW-1:0]  o_code,
  output logic              o_any
);

  assign o_any = |i_req;

  // Code for an all-zero request is don't-care; 0 keeps it deterministic.
  always_comb begin
    o_code = 2'd0;
    if (HIGH_FIRST != 0) begin
      if (i_req[3])      o_code = 2'd3;
      else if (i_req[2]) o_code = 2'd2;
      else if (i_req[1]) o_code = 2'd1;
      else               o_code = 2'd0;
    end else begin
      if (i_req[0])      o_code = 2'd0;
      else if (i_req[1]) o_code = 2'd1;
      else if (i_req[2]) o_code = 2'd2;
      else if (i_req[3]) o_code = 2'd3;
      else               o_code = 2'd0;
    end
  end

endmodule

// File: rtl/twofour_encoder_hs.sv
// Latches request pulses and serves them as 2-bit codes over a valid/ack handshake.
// Optional MULTI flag output is enabled by defining ENC_MULTI_FLAG_EN.
module twofour_encoder_hs
  import enc_pkg::*;
#(
  parameter int HIGH_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D0,
  input  logic              D1,
  input  logic              D2,
  input  logic              D3,
  input  logic              ACK,
  output logic              A,
  output logic              B,
  output logic              V,
`ifdef ENC_MULTI_FLAG_EN
  output logic              MULTI,
`endif
  output logic [NLINES-1:0] PEND
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CODEW-1:0]   r_code;
  logic [CODEW-1:0]   w_code_next;
  logic [NLINES-1:0]  r_pend;
  logic [NLINES-1:0]  w_pend_next;
  logic [NLINES-1:0]  w_clr;
  logic [CODEW-1:0]   w_enc;
  logic               w_any;
  logic               w_served;

  assign w_served = (r_state == HOLD) && ACK;
  assign w_clr    = w_served ? onehot2(r_code) : 4'b0000;
  // New requests are OR-ed in after the clear, so a same-cycle re-request survives.
  assign w_pend_next = (r_pend & ~w_clr) | {D3, D2, D1, D0};

  prio_enc4 #(.HIGH_FIRST(HIGH_FIRST)) u_prio (
    .i_req  (w_pend_next),
    .o_code (w_enc),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = HOLD;
          w_code_next  = w_enc;
        end else begin
          w_state_next = IDLE;
        end
      end
      HOLD: begin
        if (ACK) begin
          if (w_any) begin
            w_code_next = w_enc;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_state_next = HOLD;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_code  <= 2'd0;
      r_pend  <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_pend  <= w_pend_next;
    end
  end

  assign A    = r_code[1];
  assign B    = r_code[0];
  assign V    = (r_state == HOLD);
  assign PEND = r_pend;

`ifdef ENC_MULTI_FLAG_EN
  logic r_multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_multi <= 1'b0;
    end else begin
      r_multi <= |(w_pend_next & (w_pend_next - 4'd1));
    end
  end

  assign MULTI = r_multi;
`endif

endmodule

// File: tb/tb_twofour_encoder_hs.sv
// Directed self-checking bench for twofour_encoder_hs (both priority orders).
module tb_twofour_encoder_hs;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic       ack;
  logic       a_hi, b_hi, v_hi;
  logic       a_lo, b_lo, v_lo;
  logic [3:0] pend_hi, pend_lo;
`ifdef ENC_MULTI_FLAG_EN
  logic       multi_hi, multi_lo;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  twofour_encoder_hs #(.HIGH_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ACK(ack),
    .A(a_hi), .B(b_hi), .V(v_hi),
`ifdef ENC_MULTI_FLAG_EN
    .MULTI(multi_hi),
`endif
    .PEND(pend_hi)
  );

  twofour_encoder_hs #(.HIGH_FIRST(0)) dut_lo (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ACK(ack),
    .A(a_lo), .B(b_lo), .V(v_lo),
`ifdef ENC_MULTI_FLAG_EN
    .MULTI(multi_lo),
`endif
    .PEND(pend_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_hi(input string tag, input logic v, input logic [1:0] code, input logic [3:0] pend);
    check({tag, "_v"}, {3'b000, v_hi}, {3'b000, v});
    check({tag, "_ab"}, {2'b00, a_hi, b_hi}, {2'b00, code});
    check({tag, "_pend"}, pend_hi, pend);
  endtask

  task automatic check_lo(input string tag, input logic v, input logic [1:0] code, input logic [3:0] pend);
    check({tag, "_lo_v"}, {3'b000, v_lo}, {3'b000, v});
    check({tag, "_lo_ab"}, {2'b00, a_lo, b_lo}, {2'b00, code});
    check({tag, "_lo_pend"}, pend_lo, pend);
  endtask

  initial begin
    rst_n = 1'b0;
    d     = 4'b1111;
    ack   = 1'b0;

    // Reset dominates active requests
    tick();
    tick();
    check_hi("reset", 1'b0, 2'b00, 4'b0000);
`ifdef ENC_MULTI_FLAG_EN
    check("reset_multi", {3'b000, multi_hi}, 4'b0000);
`endif

    // Release with all lines high: one-cycle latency to the first code
    rst_n = 1'b1;
    tick();
    check_hi("release", 1'b1, 2'b11, 4'b1111);
    check_lo("release", 1'b1, 2'b00, 4'b1111);

    // Priority drain with ACK held high, both orders
    d   = 4'b0000;
    ack = 1'b1;
    tick();
    check_hi("prio1", 1'b1, 2'b10, 4'b0111);
    check_lo("prio1", 1'b1, 2'b01, 4'b1110);
    tick();
    check_hi("prio2", 1'b1, 2'b01, 4'b0011);
    check_lo("prio2", 1'b1, 2'b10, 4'b1100);
    tick();
    check_hi("prio3", 1'b1, 2'b00, 4'b0001);
    check_lo("prio3", 1'b1, 2'b11, 4'b1000);
    tick();
    check_hi("prio_done", 1'b0, 2'b00, 4'b0000);
    check_lo("prio_done", 1'b0, 2'b11, 4'b0000);

    // ACK while idle does nothing
    tick();
    check_hi("ack_idle", 1'b0, 2'b00, 4'b0000);
    ack = 1'b0;

    // Single pulse on D1
    d = 4'b0010;
    tick();
    check_hi("single", 1'b1, 2'b01, 4'b0010);
    d   = 4'b0000;
    ack = 1'b1;
    tick();
    check_hi("single_ack", 1'b0, 2'b01, 4'b0000);
    ack = 1'b0;

    // Hold stability: a higher request only lands in PEND
    d = 4'b0001;
    tick();
    check_hi("hold0", 1'b1, 2'b00, 4'b0001);
    d = 4'b1000;
    tick();
    check_hi("hold1", 1'b1, 2'b00, 4'b1001);
    d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_hi("hold_n", 1'b1, 2'b00, 4'b1001);
    end
    ack = 1'b1;
    tick();
    check_hi("hold_next", 1'b1, 2'b11, 4'b1000);
    tick();
    check_hi("hold_done", 1'b0, 2'b11, 4'b0000);
    ack = 1'b0;

    // Set/clear collision on bit 2: set wins
    d = 4'b0110;
    tick();
    check_hi("coll_load", 1'b1, 2'b10, 4'b0110);
    d   = 4'b0100;
    ack = 1'b1;
    tick();
    check_hi("coll", 1'b1, 2'b10, 4'b0110);
    d = 4'b0000;
    tick();
    check_hi("coll_next", 1'b1, 2'b01, 4'b0010);
    tick();
    check_hi("coll_done", 1'b0, 2'b01, 4'b0000);
    ack = 1'b0;

    // Mid-handshake reset discards pending work
    d = 4'b0110;
    tick();
    check_hi("mid_load", 1'b1, 2'b10, 4'b0110);
`ifdef ENC_MULTI_FLAG_EN
    check("mid_multi", {3'b000, multi_hi}, 4'b0001);
`endif
    d     = 4'b0000;
    rst_n = 1'b0;
    tick();
    check_hi("mid_reset", 1'b0, 2'b00, 4'b0000);
`ifdef ENC_MULTI_FLAG_EN
    check("mid_reset_multi", {3'b000, multi_hi}, 4'b0000);
`endif
    rst_n = 1'b1;
    tick();
    check_hi("post_reset", 1'b0, 2'b00, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
